// File: rtl/intv_meas.sv
// Run-once interval-measurement up-counter: counts enabled cycles between start
// and stop, captures the result in the run-once down-counter's d encoding.
module intv_meas #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            nReset,
    input  logic            rst,
    input  logic            cnt_en,
    input  logic            start,
    input  logic            stop,
    output logic            busy,
    output logic            done,
    output logic            ovf,
    output logic [SIZE-1:0] q,
    output logic [SIZE-1:0] cnt
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [SIZE-1:0] ALL_ONES = '1;

    state_t          r_state;
    logic [SIZE-1:0] r_cnt;
    logic [SIZE-1:0] r_q;
    logic            r_sat;
    logic            r_done;
    logic            r_ovf;

    // NOTE: non-blocking assignments keep every register reading the pre-edge
    // value of the others, so q captures cnt before this edge's increment.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_q     <= '0;
            r_sat   <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_q     <= '0;
            r_sat   <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                        r_sat   <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_q    <= r_cnt;
                        r_ovf  <= r_sat;
                        r_done <= 1'b1;
                    end
                    // start restarts (or chains after a capture); stop alone ends the run
                    if (start) begin
                        r_cnt <= '0;
                        r_sat <= 1'b0;
                    end else if (stop) begin
                        r_state <= IDLE;
                    end else if (cnt_en) begin
                        if (r_cnt == ALL_ONES) r_sat <= 1'b1;
                        else                   r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign ovf  = r_ovf;
    assign q    = r_q;
    assign cnt  = r_cnt;

endmodule

// File: tb/tb_intv_meas.sv
// Self-checking bench for intv_meas: vector table, directed corner cases and
// random traffic against an unbounded-count reference model (SIZE=8 and SIZE=4).
module tb_intv_meas;

    logic clk = 1'b0;
    logic nReset, rst, start, stop, cnt_en;

    logic       busy8, done8, ovf8;
    logic [7:0] q8, cnt8;
    logic       busy4, done4, ovf4;
    logic [3:0] q4, cnt4;

    intv_meas #(.SIZE(8)) dut8 (
        .clk(clk), .nReset(nReset), .rst(rst), .cnt_en(cnt_en), .start(start), .stop(stop),
        .busy(busy8), .done(done8), .ovf(ovf8), .q(q8), .cnt(cnt8)
    );

    intv_meas #(.SIZE(4)) dut4 (
        .clk(clk), .nReset(nReset), .rst(rst), .cnt_en(cnt_en), .start(start), .stop(stop),
        .busy(busy4), .done(done4), .ovf(ovf4), .q(q4), .cnt(cnt4)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: counts enabled cycles with an unbounded int and clips on read.
    int m_n[2], m_q[2];
    bit m_run[2], m_ovf[2], m_done[2];
    int m_max[2] = '{255, 15};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_n[k] = 0; m_q[k] = 0; m_run[k] = 0; m_ovf[k] = 0; m_done[k] = 0;
        end
    endtask

    function automatic int clip(int k, int v);
        return (v > m_max[k]) ? m_max[k] : v;
    endfunction

    task automatic model_step(input bit r, input bit s, input bit p, input bit e);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_n[k] = 0; m_q[k] = 0; m_run[k] = 0; m_ovf[k] = 0; m_done[k] = 0;
            end else begin
                m_done[k] = 0;
                if (!m_run[k]) begin
                    if (s) begin m_run[k] = 1; m_n[k] = 0; end
                end else begin
                    if (p) begin
                        m_q[k] = clip(k, m_n[k]);
                        m_ovf[k] = (m_n[k] > m_max[k]);
                        m_done[k] = 1;
                    end
                    if (s) m_n[k] = 0;
                    else if (p) m_run[k] = 0;
                    else if (e) m_n[k]++;
                end
            end
        end
    endtask

    function automatic logic [31:0] model_vec(int k);
        int c = clip(k, m_n[k]);
        if (k == 0) return {13'b0, m_run[0], m_done[0], m_ovf[0], 8'(m_q[0]), 8'(c)};
        return {21'b0, m_run[1], m_done[1], m_ovf[1], 4'(m_q[1]), 4'(c)};
    endfunction

    logic [31:0] dut_vec8, dut_vec4;
    assign dut_vec8 = {13'b0, busy8, done8, ovf8, q8, cnt8};
    assign dut_vec4 = {21'b0, busy4, done4, ovf4, q4, cnt4};

    // Drive one edge's inputs, then compare both DUTs to the model on the falling edge.
    task automatic cycle(input bit r, input bit s, input bit p, input bit e);
        rst = r; start = s; stop = p; cnt_en = e;
        @(posedge clk);
        model_step(r, s, p, e);
        @(negedge clk);
        check("model8", dut_vec8, model_vec(0));
        check("model4", dut_vec4, model_vec(1));
    endtask

    typedef struct {
        logic rst, start, stop, en;
        logic busy, done, ovf;
        logic [7:0] q, cnt;
    } vec_t;

    vec_t tbl[16];

    initial begin
        nReset = 1'b0; rst = 1'b0; start = 1'b0; stop = 1'b0; cnt_en = 1'b0;
        model_reset();
        #12;
        check("reset8", dut_vec8, 32'h0);
        check("reset4", dut_vec4, 32'h0);
        @(negedge clk);
        nReset = 1'b1;

        //          rst st sp en   busy done ovf q     cnt
        tbl[0]  = '{0, 1, 0, 1,   1, 0, 0, 8'd0, 8'd0};
        tbl[1]  = '{0, 0, 0, 1,   1, 0, 0, 8'd0, 8'd1};
        tbl[2]  = '{0, 0, 0, 1,   1, 0, 0, 8'd0, 8'd2};
        tbl[3]  = '{0, 0, 0, 0,   1, 0, 0, 8'd0, 8'd2};
        tbl[4]  = '{0, 0, 0, 1,   1, 0, 0, 8'd0, 8'd3};
        tbl[5]  = '{0, 0, 1, 1,   0, 1, 0, 8'd3, 8'd3};
        tbl[6]  = '{0, 0, 0, 1,   0, 0, 0, 8'd3, 8'd3};
        tbl[7]  = '{0, 0, 1, 1,   0, 0, 0, 8'd3, 8'd3};
        tbl[8]  = '{0, 1, 1, 1,   1, 0, 0, 8'd3, 8'd0};
        tbl[9]  = '{0, 0, 0, 1,   1, 0, 0, 8'd3, 8'd1};
        tbl[10] = '{0, 1, 1, 1,   1, 1, 0, 8'd1, 8'd0};
        tbl[11] = '{0, 1, 1, 0,   1, 1, 0, 8'd0, 8'd0};
        tbl[12] = '{0, 1, 0, 1,   1, 0, 0, 8'd0, 8'd0};
        tbl[13] = '{0, 0, 0, 1,   1, 0, 0, 8'd0, 8'd1};
        tbl[14] = '{1, 0, 1, 1,   0, 0, 0, 8'd0, 8'd0};
        tbl[15] = '{0, 0, 1, 1,   0, 0, 0, 8'd0, 8'd0};

        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].rst, tbl[i].start, tbl[i].stop, tbl[i].en);
            check($sformatf("tbl%0d", i), {13'b0, busy8, done8, ovf8, q8, cnt8},
                  {13'b0, tbl[i].busy, tbl[i].done, tbl[i].ovf, tbl[i].q, tbl[i].cnt});
        end

        // Basic interval: start at edge 0, stop at edge 10 -> q = 9.
        cycle(0, 1, 0, 1);
        for (int i = 1; i < 10; i++) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        check("basic_q", {24'b0, q8}, 32'd9);
        check("basic_done", {31'b0, done8}, 32'd1);
        check("basic_busy", {31'b0, busy8}, 32'd0);
        cycle(0, 0, 0, 1);
        check("basic_done_drop", {31'b0, done8}, 32'd0);

        // Alternating enable over 20 cycles -> 10 counted.
        cycle(0, 1, 0, 1);
        for (int i = 1; i <= 20; i++) cycle(0, 0, 0, (i % 2) == 1);
        cycle(0, 0, 1, 1);
        check("en_alt_q", {24'b0, q8}, 32'd10);

        // Long interval: SIZE=4 saturates, SIZE=8 does not.
        cycle(0, 1, 0, 1);
        for (int i = 1; i <= 40; i++) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        check("sat_q4", {28'b0, q4}, 32'd15);
        check("sat_ovf4", {31'b0, ovf4}, 32'd1);
        check("sat_q8", {24'b0, q8}, 32'd40);
        cycle(0, 1, 0, 1);
        for (int i = 1; i < 5; i++) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        check("after_sat_q4", {27'b0, ovf4, q4}, 32'd4);

        // Saturation boundary: N=16 fits exactly, N=17 overflows.
        cycle(0, 1, 0, 1);
        for (int i = 1; i < 16; i++) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        check("edge16", {27'b0, ovf4, q4}, 32'h0f);
        cycle(0, 1, 0, 1);
        for (int i = 1; i < 17; i++) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        check("edge17", {27'b0, ovf4, q4}, 32'h1f);

        // Asynchronous reset in the middle of a run, then an ignored stop.
        cycle(0, 1, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        #1 nReset = 1'b0;
        #1;
        model_reset();
        check("nreset8", dut_vec8, 32'h0);
        check("nreset4", dut_vec4, 32'h0);
        #1 nReset = 1'b1;
        @(negedge clk);
        cycle(0, 0, 1, 1);
        check("stop_after_nreset", dut_vec8, 32'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(63) == 0, $urandom_range(15) == 0,
                  $urandom_range(23) == 0, $urandom_range(3) != 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
